// File: rtl/shift_right_serial.sv
// Serial right shifter: one bit per clock, logical or arithmetic fill.
// Operands are captured on the accepted Start edge. The result is valid in the
// DONE cycle and stays on DataOut until the next accepted Start.
// WIDTH must equal 2**SHW.
module shift_right_serial #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] DataIn,
  input  logic [SHW-1:0]   Shamt,
  input  logic             Arith,
  output logic [WIDTH-1:0] DataOut,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   count_q;
  logic             arith_q;
  logic             busy_q;
  logic             done_q;
  logic             fill;

  // Sign fill only for an arithmetic op; the working register's MSB is the sign.
  assign fill = arith_q & data_q[WIDTH-1];

  // FSM, datapath and registered Busy/Done. Busy and Done are loaded with the
  // decode of the state being entered, so they always match state_q.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      arith_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            data_q  <= DataIn;
            count_q <= Shamt;
            arith_q <= Arith;
            busy_q  <= 1'b1;
            if (Shamt == '0) begin
              // Zero shift: result is already in place.
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHIFT;
              done_q  <= 1'b0;
            end
          end
        end
        SHIFT: begin
          data_q  <= {fill, data_q[WIDTH-1:1]};
          count_q <= count_q - SHW'(1);
          if (count_q == SHW'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign DataOut = data_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_shift_right_serial.sv
// Directed bench for shift_right_serial. Inputs are driven and outputs are
// sampled on the falling edge of Clk.
module tb_shift_right_serial;

  logic        Clk = 1'b0;
  logic        Reset, Start, Arith;
  logic [31:0] DataIn;
  logic [4:0]  Shamt;
  logic [31:0] DataOut;
  logic        Busy, Done;

  int n_tests = 0;
  int n_fail  = 0;

  shift_right_serial #(.WIDTH(32), .SHW(5)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .DataIn(DataIn),
    .Shamt(Shamt), .Arith(Arith), .DataOut(DataOut), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start one operation and wait for Done. After the accept edge the operand
  // inputs are scrambled, which must not affect the result. With inject set,
  // a second Start carrying different operands is pulsed during the shift.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] sh,
                        input logic ar, input logic [31:0] exp, input bit inject);
    int k;
    int busy_n;
    bit seen;
    @(negedge Clk);
    DataIn = d; Shamt = sh; Arith = ar; Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0; DataIn = ~d; Shamt = ~sh; Arith = ~ar;
    k = 0; busy_n = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge Clk);
      k++;
      if (Busy) busy_n++;
      if (Done) seen = 1'b1;
      if (inject && k == 2) begin
        Start = 1'b1; DataIn = 32'h1234_0000; Shamt = 5'd1; Arith = 1'b0;
      end else if (inject && k == 3) begin
        Start = 1'b0;
      end
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(k), 32'(sh) + 32'd1);
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'(sh) + 32'd1);
    chk({tag, " result"}, DataOut, exp);
    @(negedge Clk);
    chk({tag, " done_once"}, 32'(Done), 32'd0);
    chk({tag, " idle_busy"}, 32'(Busy), 32'd0);
    chk({tag, " hold"}, DataOut, exp);
  endtask

  // Operands and expected results for the back-to-back run with Start held high.
  logic [31:0] b2b_d [3] = '{32'hF0F0_0000, 32'h0000_00FF, 32'h8000_0004};
  logic        b2b_a [3] = '{1'b1, 1'b0, 1'b0};
  logic [31:0] b2b_e [3] = '{32'hFC3C_0000, 32'h0000_003F, 32'h2000_0001};

  initial begin
    int gap;
    bit seen;

    // Reset asserted together with Start: nothing may be accepted.
    Reset = 1'b1; Start = 1'b1; DataIn = 32'hDEAD_BEEF; Shamt = 5'd0; Arith = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset DataOut", DataOut, 32'h0);
    chk("reset Busy", 32'(Busy), 32'd0);
    chk("reset Done", 32'(Done), 32'd0);
    Reset = 1'b0; Start = 1'b0;
    @(negedge Clk);
    chk("post-reset idle", 32'(Busy), 32'd0);

    run_op("logical4",   32'hF000_0000, 5'd4,  1'b0, 32'h0F00_0000, 1'b0);
    run_op("arith4",     32'h8000_0010, 5'd4,  1'b1, 32'hF800_0001, 1'b0);
    run_op("logic4b",    32'h8000_0010, 5'd4,  1'b0, 32'h0800_0001, 1'b0);
    run_op("shamt0",     32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 1'b0);
    run_op("arith31",    32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_op("logic31",    32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 1'b0);
    run_op("arith31pos", 32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, 1'b0);
    run_op("inject",     32'hA5A5_0000, 5'd8,  1'b1, 32'hFFA5_A500, 1'b1);

    // Reset during the third SHIFT cycle of an 8-bit shift.
    @(negedge Clk);
    DataIn = 32'hFFFF_0000; Shamt = 5'd8; Arith = 1'b1; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (3) @(negedge Clk);
    chk("midreset busy_before", 32'(Busy), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midreset DataOut", DataOut, 32'h0);
    chk("midreset Busy", 32'(Busy), 32'd0);
    chk("midreset Done", 32'(Done), 32'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      if (Done || Busy) seen = 1'b1;
    end
    chk("midreset quiet", 32'(seen), 32'd0);
    run_op("after_reset", 32'h0000_1000, 5'd12, 1'b0, 32'h0000_0001, 1'b0);

    // Start held high with Shamt=2: Done every 4 cycles, each result from the
    // operands present at its own accept edge.
    @(negedge Clk);
    DataIn = b2b_d[0]; Arith = b2b_a[0]; Shamt = 5'd2; Start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gap = 0; seen = 1'b0;
      while (!seen && gap < 20) begin
        @(negedge Clk);
        gap++;
        if (Done) seen = 1'b1;
      end
      chk($sformatf("b2b%0d done_seen", i), 32'(seen), 32'd1);
      chk($sformatf("b2b%0d gap", i), 32'(gap), (i == 0) ? 32'd3 : 32'd4);
      chk($sformatf("b2b%0d result", i), DataOut, b2b_e[i]);
      if (i < 2) begin
        DataIn = b2b_d[i+1]; Arith = b2b_a[i+1];
      end else begin
        Start = 1'b0;
      end
    end
    repeat (2) @(negedge Clk);
    chk("b2b final idle", 32'(Busy), 32'd0);
    chk("b2b final hold", DataOut, b2b_e[2]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_right_serial.md
SHIFT_RIGHT_SERIAL -- requirements
Module: shift_right_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data width in bits.
REQ-002 The block SHALL have parameter SHW, default 5, meaning the shift-amount width; WIDTH SHALL equal 2**SHW.
REQ-003 Port Clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 Port Reset  input  1  synchronous, active-high reset.
REQ-005 Port Start  input  1  request; sampled only in IDLE.
REQ-006 Port DataIn  input  WIDTH  operand; captured on the accepted Start edge.
REQ-007 Port Shamt  input  SHW  right-shift amount, 0..WIDTH-1; captured with DataIn.
REQ-008 Port Arith  input  1  selects fill: 1 = sign fill (arithmetic), 0 = zero fill (logical); captured with DataIn.
REQ-009 Port DataOut  output  WIDTH  working or result register.
REQ-010 Port Busy  output  1  high in SHIFT and DONE states.
REQ-011 Port Done  output  1  one-cycle result-valid pulse.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with Start=1, the block SHALL load DataOut<=DataIn, count<=Shamt, and latch Arith.
REQ-014 On that same accept edge, next state SHALL be DONE if Shamt==0, else SHIFT.
REQ-015 In SHIFT, each edge SHALL do DataOut<={fill,DataOut[WIDTH-1:1]} and count<=count-1.
REQ-016 The fill bit SHALL be DataOut[WIDTH-1] if the latched Arith=1, else 0.
REQ-017 In SHIFT, when count==1 at an edge, the block SHALL perform the final shift and go to DONE.
REQ-018 In DONE, Done SHALL be 1 for exactly one cycle, DataOut SHALL hold the result, and next state SHALL be IDLE.
REQ-019 Latency SHALL be Shamt+1 cycles from the accept edge to the Done cycle; Shamt=0 SHALL give Done in the cycle after accept.
REQ-020 Result SHALL equal DataIn>>Shamt (logical) or DataIn>>>Shamt (arithmetic) on WIDTH bits, with no width extension.
REQ-021 Start in SHIFT or DONE SHALL be ignored; DataIn, Shamt and Arith changes SHALL NOT affect an operation in flight.
REQ-022 Start held high continuously SHALL be re-accepted in the IDLE cycle following DONE (back-to-back throughput Shamt+2 cycles).
REQ-023 After DONE, DataOut SHALL hold the result in IDLE until the next accepted Start.
REQ-024 Done and Busy SHALL be registered outputs decoded from state only.

Reset
REQ-025 Reset=1 at an edge SHALL force state=IDLE, DataOut=0, count=0, Busy=0, Done=0, from any state including mid-SHIFT.
REQ-026 Reset SHALL take priority over Start in the same cycle; no operation SHALL be accepted that cycle.
REQ-027 After Reset deasserts, the first Start in IDLE SHALL be accepted normally.

Verification
REQ-028 Logical shift: DataIn=0xF000_0000, Shamt=4, Arith=0 -> Done in 5th cycle after accept, DataOut=0x0F00_0000, Busy high 5 cycles.
REQ-029 Arithmetic shift: DataIn=0x8000_0010, Shamt=4, Arith=1 -> DataOut=0xF800_0001; with Arith=0 -> 0x0800_0001.
REQ-030 Boundaries: Shamt=0, DataIn=0x1234_5678 -> Done 1 cycle after accept, DataOut=0x1234_5678; Shamt=31, DataIn=0x8000_0000, Arith=1 -> 0xFFFF_FFFF after 32 cycles; Arith=0 -> 0x0000_0001.
REQ-031 Start pulsed at cycle 2 of a Shamt=8 operation with new DataIn -> ignored, result from original operands, single Done pulse.
REQ-032 Reset asserted in 3rd SHIFT cycle -> next cycle DataOut=0, Busy=0, Done=0, no Done pulse; new Start then completes correctly.
REQ-033 Start held high, Shamt=2 -> Done pulses every 4 cycles, each result matching operands sampled at its accept edge.
